// File: rtl/gray_seq_arbiter.sv
// Two-requester round-robin sequencer for a shared binary counter exposed as Gray code.
// Commands (CLEAR, LOAD, STEP_UP N, STEP_DOWN N) run to completion, then a one-cycle done pulse.
module gray_seq_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_arg,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_arg,
  output logic             req1_ready,
  input  logic             pause,
  output logic [WIDTH-1:0] gray,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic             owner
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_CLEAR = 2'd0;
  localparam logic [1:0] OP_LOAD  = 2'd1;
  localparam logic [1:0] OP_UP    = 2'd2;
  localparam logic [1:0] OP_DOWN  = 2'd3;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_rem;
  logic             r_dirDown;
  logic             r_prio;
  logic             r_owner;

  logic             w_idle;
  logic             w_grantId;
  logic             w_accept;
  logic [1:0]       w_op;
  logic [WIDTH-1:0] w_arg;
  logic             w_stepNow;
  logic             w_lastStep;

  assign w_idle = (r_state == S_IDLE);

  // r_prio names the requester that wins a tie; it always points away from the last winner.
  always_comb begin
    w_grantId = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grantId = r_prio;
    end else if (req1_valid) begin
      w_grantId = 1'b1;
    end
  end

  assign w_accept   = w_idle && (req0_valid || req1_valid);
  assign req0_ready = w_idle && req0_valid && !w_grantId;
  assign req1_ready = w_idle && req1_valid && w_grantId;

  assign w_op  = w_grantId ? req1_op  : req0_op;
  assign w_arg = w_grantId ? req1_arg : req0_arg;

  assign w_stepNow  = (r_state == S_RUN) && !pause;
  assign w_lastStep = w_stepNow && (r_rem == WIDTH'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if ((w_op == OP_UP || w_op == OP_DOWN) && (w_arg != '0)) begin
              r_state <= S_RUN;
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        S_RUN: begin
          if (w_lastStep) begin
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio  <= 1'b0;
      r_owner <= 1'b0;
    end else if (w_accept) begin
      r_prio  <= !w_grantId;
      r_owner <= w_grantId;
    end
  end

  // Step bookkeeping is latched only for STEP commands; CLEAR/LOAD never enter RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem     <= '0;
      r_dirDown <= 1'b0;
    end else if (w_accept && (w_op == OP_UP || w_op == OP_DOWN)) begin
      r_rem     <= w_arg;
      r_dirDown <= (w_op == OP_DOWN);
    end else if (w_stepNow) begin
      r_rem <= r_rem - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin <= '0;
    end else if (w_accept) begin
      case (w_op)
        OP_CLEAR: r_bin <= '0;
        OP_LOAD:  r_bin <= w_arg;
        default:  r_bin <= r_bin;
      endcase
    end else if (w_stepNow) begin
      r_bin <= r_dirDown ? (r_bin - WIDTH'(1)) : (r_bin + WIDTH'(1));
    end
  end

  assign gray    = r_bin ^ (r_bin >> 1);
  assign busy    = !w_idle;
  assign done    = (r_state == S_DONE);
  assign done_id = (r_state == S_DONE) && r_owner;
  assign owner   = r_owner;

endmodule
